hdmi_pix_rd: RTL and testbench

HDMI_PIX_RD -- requirements
Module: hdmi_pix_rd

---
 rtl/video_pkg.sv | 43 ++++
 rtl/hdmi_pix_rd_if.sv | 38 +++
 rtl/vid_timing_gen.sv | 64 ++++++
 rtl/hdmi_pix_rd.sv | 142 ++++++++++++++
 tb/tb_hdmi_pix_rd.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// video_pkg: types and constants shared by the HDMI pixel reader.
//   pix_state_e   - reader FSM states (IDLE, WAIT_FILL, RUN)
//   rgb565_t      - packed RGB565 word as delivered by the prefetch FIFO
//   rgb888_t      - packed RGB888 word as driven to the video output
//   rgb565_to_888 - channel expansion by MSB replication
package video_pkg;

  localparam int R5_W     = 5;
  localparam int G6_W     = 6;
  localparam int B5_W     = 5;
  localparam int C8_W     = 8;
  localparam int RGB565_W = R5_W + G6_W + B5_W;
  localparam int RGB888_W = 3 * C8_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FILL = 2'd1,
    ST_RUN       = 2'd2
  } pix_state_e;

  typedef struct packed {
    logic [R5_W-1:0] r;
    logic [G6_W-1:0] g;
    logic [B5_W-1:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [C8_W-1:0] r;
    logic [C8_W-1:0] g;
    logic [C8_W-1:0] b;
  } rgb888_t;

  // Replicating the top bits into the new LSBs maps full-scale to full-scale
  // (5'h1F -> 8'hFF) and zero to zero.
  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    rgb888_t o;
    o.r = {p.r, p.r[4:2]};
    o.g = {p.g, p.g[5:4]};
    o.b = {p.b, p.b[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/hdmi_pix_rd_if.sv
// hdmi_pix_rd_if: prefetch-FIFO read port plus video output bundle.
//   fifo_rd_en   - pop strobe (reader -> FIFO)
//   fifo_rd_vld  - FIFO holds a valid word (FIFO -> reader)
//   fifo_rd_data - RGB565 word at the FIFO head (FIFO -> reader)
//   hs_out, vs_out, de_out, rgb_out - registered video timing and pixel
// master: the pixel reader; slave: FIFO / video sink side.
interface hdmi_pix_rd_if;
  import video_pkg::*;

  logic                fifo_rd_en;
  logic                fifo_rd_vld;
  logic [RGB565_W-1:0] fifo_rd_data;
  logic                hs_out;
  logic                vs_out;
  logic                de_out;
  logic [RGB888_W-1:0] rgb_out;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_vld,
    input  fifo_rd_data,
    output hs_out,
    output vs_out,
    output de_out,
    output rgb_out
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_vld,
    output fifo_rd_data,
    input  hs_out,
    input  vs_out,
    input  de_out,
    input  rgb_out
  );

endinterface

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: horizontal/vertical raster counters and decoded timing.
//   clk, rst     - pixel clock, synchronous active-high reset
//   run          - count enable; while low both counters are held at 0
//   active       - current position is inside the visible area
//   hs, vs       - sync windows (unregistered, positive polarity)
//   vblank_start - first clock of the vertical blank (h=0, v=V_ACTIVE)
//   frame_end    - last clock of the frame (h=H_TOTAL-1, v=V_TOTAL-1)
// Each line/frame is laid out as active, front porch, sync, back porch.
module vid_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic active,
  output logic hs,
  output logic vs,
  output logic vblank_start,
  output logic frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic          h_last;
  logic          v_last;

  assign h_last = (int'(h_cnt_reg) == H_TOTAL - 1);
  assign v_last = (int'(v_cnt_reg) == V_TOTAL - 1);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_last) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= v_last ? '0 : v_cnt_reg + 1'b1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    active       = (int'(h_cnt_reg) < H_ACTIVE) && (int'(v_cnt_reg) < V_ACTIVE);
    hs           = (int'(h_cnt_reg) >= H_ACTIVE + H_FP) &&
                   (int'(h_cnt_reg) <  H_ACTIVE + H_FP + H_SYNC);
    vs           = (int'(v_cnt_reg) >= V_ACTIVE + V_FP) &&
                   (int'(v_cnt_reg) <  V_ACTIVE + V_FP + V_SYNC);
    vblank_start = (h_cnt_reg == '0) && (int'(v_cnt_reg) == V_ACTIVE);
    frame_end    = h_last && v_last;
  end

endmodule

// File: rtl/hdmi_pix_rd.sv
// hdmi_pix_rd: pulls RGB565 pixels from a prefetch FIFO and emits a
// registered RGB888 video stream with positive-polarity HS/VS/DE.
//   clk, rst      - pixel clock, synchronous active-high reset
//   en            - run request; dropping it lets the current frame finish
//   clr_underflow - clears the sticky underflow flag (a new miss wins)
//   frame_req     - one-cycle request to the DDR reader to fetch a frame
//   underflow     - sticky: an active pixel found the FIFO empty
//   vif           - FIFO read port and video outputs (master side)
// The FIFO pop is combinational; all video outputs and frame_req are
// registered one cycle after the counter state they describe.
module hdmi_pix_rd
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr_underflow,
  output logic frame_req,
  output logic underflow,
  hdmi_pix_rd_if.master vif
);

  pix_state_e          state_reg;
  pix_state_e          state_next;
  logic                frame_req_reg;
  logic                frame_req_next;
  logic                de_reg;
  logic                hs_reg;
  logic                vs_reg;
  logic [RGB888_W-1:0] rgb_reg;
  logic                underflow_reg;

  logic run;
  logic active;
  logic hs;
  logic vs;
  logic vblank_start;
  logic frame_end;
  logic pix_pop;
  logic pix_miss;

  assign run = (state_reg == ST_RUN);

  vid_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .active       (active),
    .hs           (hs),
    .vs           (vs),
    .vblank_start (vblank_start),
    .frame_end    (frame_end)
  );

  // Counters sit at 0 outside RUN, so the decoded flags must be gated.
  assign pix_pop  = run && active && vif.fifo_rd_vld;
  assign pix_miss = run && active && !vif.fifo_rd_vld;

  always_comb begin
    state_next     = state_reg;
    frame_req_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (en) begin
          state_next     = ST_WAIT_FILL;
          frame_req_next = 1'b1;
        end
      end
      ST_WAIT_FILL: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (vif.fifo_rd_vld) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Prefetch for the next frame is only requested while still enabled.
        if (vblank_start && en) begin
          frame_req_next = 1'b1;
        end
        if (frame_end && !en) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      frame_req_reg <= 1'b0;
      de_reg        <= 1'b0;
      hs_reg        <= 1'b0;
      vs_reg        <= 1'b0;
      rgb_reg       <= '0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_req_reg <= frame_req_next;
      // A missed pixel still shows as active, just black.
      de_reg        <= run && active;
      hs_reg        <= run && hs;
      vs_reg        <= run && vs;
      rgb_reg       <= pix_pop ? RGB888_W'(rgb565_to_888(rgb565_t'(vif.fifo_rd_data))) : '0;
      if (pix_miss) begin
        underflow_reg <= 1'b1;
      end else if (clr_underflow) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  assign vif.fifo_rd_en = pix_pop;
  assign vif.hs_out     = hs_reg;
  assign vif.vs_out     = vs_reg;
  assign vif.de_out     = de_reg;
  assign vif.rgb_out    = rgb_reg;
  assign frame_req      = frame_req_reg;
  assign underflow      = underflow_reg;

endmodule

// File: tb/tb_hdmi_pix_rd.sv
// tb_hdmi_pix_rd: directed and randomized stimulus for hdmi_pix_rd on a
// small raster (14 x 7 total, 8 x 4 active). The reference model tracks
// the reader as a mode plus a linear position within the frame and derives
// expected timing and pixels arithmetically from that position.
module tb_hdmi_pix_rd;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr_underflow;
  logic        frame_req;
  logic        underflow;
  logic [15:0] fifo_word;
  bit          incr_mode;

  hdmi_pix_rd_if vif ();

  assign vif.fifo_rd_data = fifo_word;

  hdmi_pix_rd #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .clr_underflow (clr_underflow),
    .frame_req     (frame_req),
    .underflow     (underflow),
    .vif           (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: 0 = idle, 1 = waiting for FIFO fill, 2 = running.
  int m_mode = 0;
  int m_t    = 0;
  bit m_uf   = 1'b0;

  int cnt_pop, cnt_fr, cnt_hs, cnt_vs, cnt_de;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] p);
    int r, g, b;
    r = int'(p) / 2048;
    g = (int'(p) / 32) % 64;
    b = int'(p) % 32;
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return 24'(r * 65536 + g * 256 + b);
  endfunction

  task automatic clear_tally();
    cnt_pop = 0; cnt_fr = 0; cnt_hs = 0; cnt_vs = 0; cnt_de = 0;
  endtask

  // One clock: check the combinational pop mid-cycle, then the registered
  // outputs just after the rising edge.
  task automatic step();
    bit          run, act, pop;
    int          h, v;
    logic        e_de, e_hs, e_vs, e_fr;
    logic [23:0] e_rgb;
    @(negedge clk);
    run = (m_mode == 2);
    h   = m_t % H_TOTAL;
    v   = m_t / H_TOTAL;
    act = run && (h < H_ACTIVE) && (v < V_ACTIVE);
    chk("fifo_rd_en", 32'(vif.fifo_rd_en), 32'(act && vif.fifo_rd_vld));
    pop = vif.fifo_rd_en;
    if (rst) begin
      e_de = 0; e_hs = 0; e_vs = 0; e_fr = 0; e_rgb = '0;
      m_mode = 0; m_t = 0; m_uf = 0;
    end else begin
      e_de  = act;
      e_hs  = run && (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
      e_vs  = run && (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
      e_rgb = (act && vif.fifo_rd_vld) ? expand(fifo_word) : 24'h0;
      e_fr  = ((m_mode == 0) && en) || (run && h == 0 && v == V_ACTIVE && en);
      if (act && !vif.fifo_rd_vld) m_uf = 1;
      else if (clr_underflow)      m_uf = 0;
      case (m_mode)
        0: if (en) m_mode = 1;
        1: begin
          if (!en) m_mode = 0;
          else if (vif.fifo_rd_vld) begin m_mode = 2; m_t = 0; end
        end
        default: begin
          if (m_t == FRAME - 1) begin
            m_t = 0;
            if (!en) m_mode = 0;
          end else begin
            m_t++;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    chk("de_out",    32'(vif.de_out),  32'(e_de));
    chk("hs_out",    32'(vif.hs_out),  32'(e_hs));
    chk("vs_out",    32'(vif.vs_out),  32'(e_vs));
    chk("rgb_out",   32'(vif.rgb_out), 32'(e_rgb));
    chk("frame_req", 32'(frame_req),   32'(e_fr));
    chk("underflow", 32'(underflow),   32'(m_uf));
    cnt_pop += int'(pop);
    cnt_fr  += int'(frame_req);
    cnt_hs  += int'(vif.hs_out);
    cnt_vs  += int'(vif.vs_out);
    cnt_de  += int'(vif.de_out);
    if (pop && incr_mode) fifo_word = fifo_word + 16'd1;
  endtask

  initial begin
    bit reached;
    rst = 1; en = 0; clr_underflow = 0; fifo_word = 16'h0; incr_mode = 1;
    vif.fifo_rd_vld = 0;
    clear_tally();

    // Reset state
    repeat (3) step();
    chk("reset_underflow", 32'(underflow), 32'd0);

    // Enabled but FIFO empty: one request, stuck waiting, no pops
    rst = 0; en = 1;
    clear_tally();
    repeat (10) step();
    chk("wait_frame_req_cnt", 32'(cnt_fr),  32'd1);
    chk("wait_pop_cnt",       32'(cnt_pop), 32'd0);
    chk("wait_de_cnt",        32'(cnt_de),  32'd0);

    // FIFO fills; one full frame of incrementing data
    vif.fifo_rd_vld = 1;
    step();
    clear_tally();
    repeat (FRAME) step();
    chk("frame_pop_cnt",       32'(cnt_pop), 32'(H_ACTIVE * V_ACTIVE));
    chk("frame_hs_cnt",        32'(cnt_hs),  32'(H_SYNC * V_TOTAL));
    chk("frame_vs_cnt",        32'(cnt_vs),  32'(H_TOTAL * V_SYNC));
    chk("frame_frame_req_cnt", 32'(cnt_fr),  32'd1);

    // Colour expansion of magenta
    fifo_word = 16'hF81F;
    step();
    chk("rgb_magenta", 32'(vif.rgb_out), 32'h00FF00FF);

    // Underflow on pixel 3 of line 1, then clear
    for (int i = 0; i < 2 * FRAME && m_t != H_TOTAL + 3; i++) step();
    vif.fifo_rd_vld = 0;
    step();
    chk("uf_de",        32'(vif.de_out),  32'd1);
    chk("uf_rgb",       32'(vif.rgb_out), 32'd0);
    chk("uf_flag",      32'(underflow),   32'd1);
    vif.fifo_rd_vld = 1;
    repeat (3) step();
    chk("uf_sticky",    32'(underflow),   32'd1);
    clr_underflow = 1;
    step();
    clr_underflow = 0;
    chk("uf_cleared",   32'(underflow),   32'd0);

    // Drop en at line 2: frame completes without a blank-time request
    for (int i = 0; i < 2 * FRAME && m_t != 2 * H_TOTAL; i++) step();
    en = 0;
    clear_tally();
    for (int i = 0; i < 2 * FRAME && m_mode == 2; i++) step();
    chk("stop_frame_req_cnt", 32'(cnt_fr),  32'd0);
    chk("stop_pop_cnt",       32'(cnt_pop), 32'(H_ACTIVE * (V_ACTIVE - 2)));
    clear_tally();
    repeat (5) step();
    chk("idle_pop_cnt", 32'(cnt_pop), 32'd0);
    chk("idle_de_cnt",  32'(cnt_de),  32'd0);
    chk("idle_hs_cnt",  32'(cnt_hs + cnt_vs + cnt_fr), 32'd0);

    // Randomized traffic against the model
    incr_mode = 0;
    for (int i = 0; i < 400; i++) begin
      en              = ($urandom_range(0, 99) < 97);
      vif.fifo_rd_vld = ($urandom_range(0, 9) < 8);
      fifo_word       = 16'($urandom);
      clr_underflow   = ($urandom_range(0, 19) == 0);
      step();
    end

    // Reset in the middle of an active line
    en = 1; vif.fifo_rd_vld = 1; clr_underflow = 0; incr_mode = 1;
    reached = 0;
    for (int i = 0; i < 3 * FRAME && !reached; i++) begin
      step();
      reached = (m_mode == 2) && (m_t % H_TOTAL == 4) && (m_t / H_TOTAL < V_ACTIVE);
    end
    chk("midline_reached", 32'(reached), 32'd1);
    rst = 1;
    step();
    chk("rst_de",        32'(vif.de_out),  32'd0);
    chk("rst_rgb",       32'(vif.rgb_out), 32'd0);
    chk("rst_underflow", 32'(underflow),   32'd0);
    rst = 0;
    step();
    chk("restart_frame_req", 32'(frame_req), 32'd1);
    step();
    step();
    chk("restart_de", 32'(vif.de_out), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
